// File: rtl/tcm_loader_if.sv
// TCM access port: one request channel from the loader to a tightly coupled memory.
//   master (loader): cs, addr, wen, wdata out; rdata, ready in
//   slave  (memory): cs, addr, wen, wdata in;  rdata, ready out
//   wen == 0 with cs == 1 is a read; rdata is valid RD_LAT cycles after acceptance.
interface tcm_loader_if #(
    parameter int unsigned WORD_WTH     = 32,
    parameter int unsigned MEM_ADDR_WTH = 16,
    parameter int unsigned MASK_WTH     = 4
);
    logic                    cs;
    logic [MEM_ADDR_WTH-1:0] addr;
    logic [MASK_WTH-1:0]     wen;
    logic [WORD_WTH-1:0]     wdata;
    logic [WORD_WTH-1:0]     rdata;
    logic                    ready;

    modport master (output cs, addr, wen, wdata, input  rdata, ready);
    modport slave  (input  cs, addr, wen, wdata, output rdata, ready);
endinterface

// File: rtl/tcm_loader.sv
// TCM loader: packs a little-endian byte stream into words, writes them as a
// contiguous block into ITCM or DTCM, optionally reads the block back and
// compares its sum with the write checksum. Holds the CPU in reset meanwhile.
//   clk, rst (async, active-low)
//   start/target/base_addr/word_cnt/verify_en : load request, latched in IDLE
//   in_valid/in_data/in_ready                 : byte stream
//   itcm, dtcm                                : TCM access ports (master side)
//   cpu_hold, busy, done, err, checksum       : status (all registered)
module tcm_loader #(
    parameter int unsigned WORD_WTH     = 32,
    parameter int unsigned MEM_ADDR_WTH = 16,
    parameter int unsigned MASK_WTH     = 4,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    target,
    input  logic [MEM_ADDR_WTH-1:0] base_addr,
    input  logic [15:0]             word_cnt,
    input  logic                    verify_en,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    tcm_loader_if.master            itcm,
    tcm_loader_if.master            dtcm,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [WORD_WTH-1:0]     checksum
);
    localparam int unsigned CNT_WTH  = 16;
    localparam int unsigned BYTES    = WORD_WTH / 8;
    localparam int unsigned BCNT_WTH = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned LAT_WTH  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BCNT_WTH-1:0] BCNT_LAST = BCNT_WTH'(BYTES - 1);
    localparam logic [LAT_WTH-1:0]  LAT_LAST  = LAT_WTH'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_VRD, S_VWAIT, S_VCHK, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    tgt_q, tgt_d;
    logic                    ver_q, ver_d;
    logic [MEM_ADDR_WTH-1:0] base_q, base_d;
    logic [CNT_WTH-1:0]      cnt_q, cnt_d;
    logic [CNT_WTH-1:0]      idx_q, idx_d;
    logic [CNT_WTH-1:0]      ridx_q, ridx_d;
    logic [BCNT_WTH-1:0]     bcnt_q, bcnt_d;
    logic [LAT_WTH-1:0]      lat_q, lat_d;
    logic [WORD_WTH-1:0]     word_q, word_d;
    logic [WORD_WTH-1:0]     vsum_q, vsum_d;
    logic [WORD_WTH-1:0]     checksum_q, checksum_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    in_ready_q, in_ready_d;

    logic                    itcm_cs_q, itcm_cs_d, dtcm_cs_q, dtcm_cs_d;
    logic [MEM_ADDR_WTH-1:0] itcm_addr_q, itcm_addr_d, dtcm_addr_q, dtcm_addr_d;
    logic [MASK_WTH-1:0]     itcm_wen_q, itcm_wen_d, dtcm_wen_q, dtcm_wen_d;
    logic [WORD_WTH-1:0]     itcm_wdata_q, itcm_wdata_d, dtcm_wdata_q, dtcm_wdata_d;

    logic                    sel_ready;
    logic [WORD_WTH-1:0]     sel_rdata;
    logic                    acc_cs;
    logic [MASK_WTH-1:0]     acc_wen;
    logic [MEM_ADDR_WTH-1:0] acc_addr;
    logic [WORD_WTH-1:0]     acc_wdata;
    logic [CNT_WTH-1:0]      acc_idx;

    // Only the latched target's response is ever looked at.
    assign sel_ready = tgt_q ? dtcm.ready : itcm.ready;
    assign sel_rdata = tgt_q ? dtcm.rdata : itcm.rdata;

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        ver_d      = ver_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ridx_d     = ridx_q;
        bcnt_d     = bcnt_q;
        lat_d      = lat_q;
        word_d     = word_q;
        vsum_d     = vsum_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cpu_hold_d = cpu_hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_d      = target;
                    ver_d      = verify_en;
                    base_d     = base_addr;
                    cnt_d      = word_cnt;
                    idx_d      = '0;
                    ridx_d     = '0;
                    bcnt_d     = '0;
                    vsum_d     = '0;
                    checksum_d = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                    state_d    = (word_cnt == '0) ? S_DONE : S_COLLECT;
                end else begin
                    // Nothing to load after reset: let the CPU run.
                    cpu_hold_d = 1'b0;
                end
            end
            S_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    // Right shift: first byte ends up in the low lane.
                    word_d = {in_data, word_q[WORD_WTH-1:8]};
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_WTH'(1);
                    end
                end
            end
            S_WRITE: begin
                if (sel_ready) begin
                    checksum_d = checksum_q + word_q;
                    idx_d      = idx_q + CNT_WTH'(1);
                    if (idx_d == cnt_q) begin
                        state_d = ver_q ? S_VRD : S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_VRD: begin
                if (sel_ready) begin
                    lat_d   = '0;
                    state_d = S_VWAIT;
                end
            end
            S_VWAIT: begin
                if (lat_q == LAT_LAST) begin
                    vsum_d  = vsum_q + sel_rdata;
                    ridx_d  = ridx_q + CNT_WTH'(1);
                    state_d = (ridx_d < cnt_q) ? S_VRD : S_VCHK;
                end else begin
                    lat_d = lat_q + LAT_WTH'(1);
                end
            end
            S_VCHK: begin
                err_d   = (vsum_q != checksum_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                cpu_hold_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs follow the state being entered so they line up with it.
        in_ready_d = (state_d == S_COLLECT);
        acc_cs     = (state_d == S_WRITE) || (state_d == S_VRD);
        acc_idx    = (state_d == S_VRD) ? ridx_d : idx_d;
        acc_addr   = acc_cs ? (base_d + MEM_ADDR_WTH'(32'(acc_idx) * 32'(BYTES))) : '0;
        acc_wen    = (state_d == S_WRITE) ? '1 : '0;
        acc_wdata  = (state_d == S_WRITE) ? word_d : '0;

        // The unselected port stays fully quiet.
        itcm_cs_d    = acc_cs & ~tgt_d;
        itcm_addr_d  = tgt_d ? '0 : acc_addr;
        itcm_wen_d   = tgt_d ? '0 : acc_wen;
        itcm_wdata_d = tgt_d ? '0 : acc_wdata;
        dtcm_cs_d    = acc_cs & tgt_d;
        dtcm_addr_d  = tgt_d ? acc_addr : '0;
        dtcm_wen_d   = tgt_d ? acc_wen : '0;
        dtcm_wdata_d = tgt_d ? acc_wdata : '0;
    end

    // State and output registers; reset drops any request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tgt_q        <= 1'b0;
            ver_q        <= 1'b0;
            base_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            ridx_q       <= '0;
            bcnt_q       <= '0;
            lat_q        <= '0;
            word_q       <= '0;
            vsum_q       <= '0;
            checksum_q   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
            in_ready_q   <= 1'b0;
            itcm_cs_q    <= 1'b0;
            itcm_addr_q  <= '0;
            itcm_wen_q   <= '0;
            itcm_wdata_q <= '0;
            dtcm_cs_q    <= 1'b0;
            dtcm_addr_q  <= '0;
            dtcm_wen_q   <= '0;
            dtcm_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            ver_q        <= ver_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            ridx_q       <= ridx_d;
            bcnt_q       <= bcnt_d;
            lat_q        <= lat_d;
            word_q       <= word_d;
            vsum_q       <= vsum_d;
            checksum_q   <= checksum_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cpu_hold_q   <= cpu_hold_d;
            in_ready_q   <= in_ready_d;
            itcm_cs_q    <= itcm_cs_d;
            itcm_addr_q  <= itcm_addr_d;
            itcm_wen_q   <= itcm_wen_d;
            itcm_wdata_q <= itcm_wdata_d;
            dtcm_cs_q    <= dtcm_cs_d;
            dtcm_addr_q  <= dtcm_addr_d;
            dtcm_wen_q   <= dtcm_wen_d;
            dtcm_wdata_q <= dtcm_wdata_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign checksum   = checksum_q;
    assign itcm.cs    = itcm_cs_q;
    assign itcm.addr  = itcm_addr_q;
    assign itcm.wen   = itcm_wen_q;
    assign itcm.wdata = itcm_wdata_q;
    assign dtcm.cs    = dtcm_cs_q;
    assign dtcm.addr  = dtcm_addr_q;
    assign dtcm.wen   = dtcm_wen_q;
    assign dtcm.wdata = dtcm_wdata_q;
endmodule
